// File: rtl/id_ex_stage_if.sv
// Bundle of decode, hazard, forwarding and ALU-side signals for the ID/EX stage.
// The slave modport is the stage itself; the master modport is its environment.
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 4
`endif

interface id_ex_stage_if #(
    parameter int ALU_CTRL_W = `ALU_CONTROL_SIZE,
    parameter int XLEN       = 32
);
    logic                  valid_i;
    logic [ALU_CTRL_W-1:0] alu_control_i;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic [4:0]            rs1_addr_i;
    logic [4:0]            rs2_addr_i;
    logic [4:0]            rd_addr_i;
    logic [XLEN-1:0]       imm_i;
    logic [XLEN-1:0]       pc_i;
    logic [1:0]            src_a_sel_i;
    logic                  src_b_sel_i;
    logic                  reg_write_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  exm_reg_write_i;
    logic [4:0]            exm_rd_i;
    logic [XLEN-1:0]       exm_result_i;
    logic                  mwb_reg_write_i;
    logic [4:0]            mwb_rd_i;
    logic [XLEN-1:0]       mwb_result_i;

    logic                  valid_o;
    logic [ALU_CTRL_W-1:0] alu_control_o;
    logic [XLEN-1:0]       src_a_o;
    logic [XLEN-1:0]       src_b_o;
    logic [XLEN-1:0]       store_data_o;
    logic [4:0]            rd_addr_o;
    logic                  reg_write_o;
    logic [XLEN-1:0]       pc_o;

    modport master (
        output valid_i, alu_control_i, rs1_data_i, rs2_data_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, imm_i, pc_i, src_a_sel_i, src_b_sel_i, reg_write_i,
               stall_i, flush_i, exm_reg_write_i, exm_rd_i, exm_result_i,
               mwb_reg_write_i, mwb_rd_i, mwb_result_i,
        input  valid_o, alu_control_o, src_a_o, src_b_o, store_data_o, rd_addr_o,
               reg_write_o, pc_o
    );

    modport slave (
        input  valid_i, alu_control_i, rs1_data_i, rs2_data_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, imm_i, pc_i, src_a_sel_i, src_b_sel_i, reg_write_i,
               stall_i, flush_i, exm_reg_write_i, exm_rd_i, exm_result_i,
               mwb_reg_write_i, mwb_rd_i, mwb_result_i,
        output valid_o, alu_control_o, src_a_o, src_b_o, store_data_o, rd_addr_o,
               reg_write_o, pc_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall/flush and operand muxing.
// Define ID_EX_FWD_EN to add EX/MEM + MEM/WB forwarding, stall refresh and write-through.
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 4
`endif

module id_ex_stage #(
    parameter int ALU_CTRL_W = `ALU_CONTROL_SIZE,
    parameter int XLEN       = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    id_ex_stage_if.slave bus
);
    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2,
        SRC_A_RSVD = 2'd3
    } src_a_sel_e;

    logic                  r_valid;
    logic [ALU_CTRL_W-1:0] r_alu_control;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [4:0]            r_rs1_addr;
    logic [4:0]            r_rs2_addr;
    logic [4:0]            r_rd_addr;
    logic [XLEN-1:0]       r_imm;
    logic [XLEN-1:0]       r_pc;
    src_a_sel_e            r_src_a_sel;
    logic                  r_src_b_sel;
    logic                  r_reg_write;

    logic [XLEN-1:0]       w_fwd_rs1;
    logic [XLEN-1:0]       w_fwd_rs2;
    logic [XLEN-1:0]       w_load_rs1;
    logic [XLEN-1:0]       w_load_rs2;
    logic                  w_refresh_rs1;
    logic                  w_refresh_rs2;

`ifdef ID_EX_FWD_EN
    logic w_exm_hit_rs1, w_exm_hit_rs2;
    logic w_mwb_hit_rs1, w_mwb_hit_rs2;

    assign w_exm_hit_rs1 = bus.exm_reg_write_i && (bus.exm_rd_i != 5'd0) && (bus.exm_rd_i == r_rs1_addr);
    assign w_exm_hit_rs2 = bus.exm_reg_write_i && (bus.exm_rd_i != 5'd0) && (bus.exm_rd_i == r_rs2_addr);
    assign w_mwb_hit_rs1 = bus.mwb_reg_write_i && (bus.mwb_rd_i != 5'd0) && (bus.mwb_rd_i == r_rs1_addr);
    assign w_mwb_hit_rs2 = bus.mwb_reg_write_i && (bus.mwb_rd_i != 5'd0) && (bus.mwb_rd_i == r_rs2_addr);

    // A write-back retiring during a stall would otherwise be lost to the held operand.
    assign w_refresh_rs1 = w_mwb_hit_rs1;
    assign w_refresh_rs2 = w_mwb_hit_rs2;

    // Register file has no internal bypass, so a same-cycle write-back is captured directly.
    assign w_load_rs1 = (bus.mwb_reg_write_i && (bus.mwb_rd_i != 5'd0) && (bus.mwb_rd_i == bus.rs1_addr_i))
                        ? bus.mwb_result_i : bus.rs1_data_i;
    assign w_load_rs2 = (bus.mwb_reg_write_i && (bus.mwb_rd_i != 5'd0) && (bus.mwb_rd_i == bus.rs2_addr_i))
                        ? bus.mwb_result_i : bus.rs2_data_i;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        if (r_rs1_addr == 5'd0)  w_fwd_rs1 = '0;
        else if (w_exm_hit_rs1)  w_fwd_rs1 = bus.exm_result_i;
        else if (w_mwb_hit_rs1)  w_fwd_rs1 = bus.mwb_result_i;
        if (r_rs2_addr == 5'd0)  w_fwd_rs2 = '0;
        else if (w_exm_hit_rs2)  w_fwd_rs2 = bus.exm_result_i;
        else if (w_mwb_hit_rs2)  w_fwd_rs2 = bus.mwb_result_i;
    end
`else
    logic w_fwd_unused;

    assign w_fwd_rs1     = r_rs1_data;
    assign w_fwd_rs2     = r_rs2_data;
    assign w_load_rs1    = bus.rs1_data_i;
    assign w_load_rs2    = bus.rs2_data_i;
    assign w_refresh_rs1 = 1'b0;
    assign w_refresh_rs2 = 1'b0;
    assign w_fwd_unused  = ^{bus.exm_reg_write_i, bus.exm_rd_i, bus.exm_result_i,
                             bus.mwb_reg_write_i, bus.mwb_rd_i, bus.mwb_result_i,
                             r_rs1_addr, r_rs2_addr};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_valid       <= 1'b0;
            r_alu_control <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd_addr     <= '0;
            r_imm         <= '0;
            r_pc          <= '0;
            r_src_a_sel   <= SRC_A_RS1;
            r_src_b_sel   <= 1'b0;
            r_reg_write   <= 1'b0;
        end else if (bus.stall_i) begin
            if (w_refresh_rs1) r_rs1_data <= bus.mwb_result_i;
            if (w_refresh_rs2) r_rs2_data <= bus.mwb_result_i;
        end else begin
            r_valid       <= bus.valid_i;
            r_alu_control <= bus.alu_control_i;
            r_rs1_data    <= w_load_rs1;
            r_rs2_data    <= w_load_rs2;
            r_rs1_addr    <= bus.rs1_addr_i;
            r_rs2_addr    <= bus.rs2_addr_i;
            r_rd_addr     <= bus.rd_addr_i;
            r_imm         <= bus.imm_i;
            r_pc          <= bus.pc_i;
            r_src_a_sel   <= src_a_sel_e'(bus.src_a_sel_i);
            r_src_b_sel   <= bus.src_b_sel_i;
            r_reg_write   <= bus.reg_write_i;
        end
    end

    always_comb begin
        bus.src_a_o = '0;
        case (r_src_a_sel)
            SRC_A_RS1: bus.src_a_o = w_fwd_rs1;
            SRC_A_PC:  bus.src_a_o = r_pc;
            default:   bus.src_a_o = '0;
        endcase
    end

    assign bus.src_b_o       = r_src_b_sel ? r_imm : w_fwd_rs2;
    assign bus.store_data_o  = w_fwd_rs2;
    assign bus.valid_o       = r_valid;
    assign bus.alu_control_o = r_alu_control;
    assign bus.rd_addr_o     = r_rd_addr;
    assign bus.reg_write_o   = r_reg_write & r_valid;
    assign bus.pc_o          = r_pc;
endmodule
